// File: rtl/galaksija_serial_keyboard_if.sv
// Key-matrix read path shared between the CPU side and the serial keyboard front end.
// Latency: none; key_out is combinational in addr and key_in.
// Backpressure: none; the CPU may read any matrix address on any cycle.
interface galaksija_serial_keyboard_if;
  logic [5:0] addr;     // CPU address bits [5:0] during a matrix read
  logic       key_in;   // PS/2 matrix bit for addr, active-low
  logic       key_out;  // merged matrix bit, active-low

  modport master (output addr, output key_in, input key_out);
  modport slave  (input addr, input key_in, output key_out);
endinterface

// File: rtl/galaksija_serial_keyboard.sv
// Serial (8N1) keyboard front end: bytes -> matrix indices -> timed key presses on the matrix path.
// Latency: press goes active 3 clk after the stop-bit sample when idle and the FIFO is empty.
// Backpressure: none toward the line; a full index FIFO drops the byte and sets sticky overflow.

// Small synchronous FIFO: pointers carry one extra wrap bit to tell full from empty.
// Latency: a write is visible on rd_vld/rd_dat the next cycle.
// Backpressure: wr_rdy low when full unless a pop frees a slot in the same cycle.
module galaksija_kbd_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, push, pop;

  // Occupancy flags and pointer advance; a same-cycle pop makes room for a write when full.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = rd_rdy & ~empty;
    push     = wr_vld & (~full | pop);
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  assign wr_rdy = ~full | pop;
  assign rd_vld = ~empty;
  assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end
endmodule

module galaksija_serial_keyboard #(
  parameter int F_CLK      = 25000000,
  parameter int BAUD       = 115200,
  parameter int HOLD_MS    = 20,
  parameter int GAP_MS     = 20,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ser_rx,
  galaksija_serial_keyboard_if.slave  mtx,
  output logic                        frame_err,
  output logic                        overflow,
  output logic                        busy
);
  localparam int DIV      = F_CLK / BAUD;
  localparam int HOLD_CYC = (F_CLK / 1000) * HOLD_MS;
  localparam int GAP_CYC  = (F_CLK / 1000) * GAP_MS;
  localparam int TMR_MAX  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  // Counters are loaded with N-1, so $clog2(N) bits always hold the load value.
  localparam int DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int TMR_W    = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(DIV / 2 - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_PRESS, P_GAP} press_state_t;

  // ---------------------------------------------------------------- synchroniser
  logic sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic rx_s;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_comb begin
    sync1_d   = ser_rx;
    sync2_d   = sync1_q;
    rx_prev_d = sync2_q;
  end

  assign rx_s = sync2_q;

  // Synchroniser registers idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      rx_prev_q <= rx_prev_d;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  rx_state_t        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld_q, byte_vld_d;
  logic             frame_err_q, frame_err_d;

  // Bit timing: start checked mid-bit, then data and stop one bit period apart, LSB first.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = R_START;
          rx_cnt_d   = HALF_LOAD;
        end
      end
      R_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s) begin
            rx_state_d = R_IDLE;        // line bounced back high: not a real start bit
          end else begin
            rx_state_d = R_DATA;
            rx_cnt_d   = DIV_LOAD;
            bit_cnt_d  = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == '0) begin
          shift_d  = {rx_s, shift_q[7:1]};
          rx_cnt_d = DIV_LOAD;
          if (bit_cnt_q == 3'd7) rx_state_d = R_STOP;
          else                   bit_cnt_d  = bit_cnt_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rx_s) begin
            byte_vld_d = 1'b1;
            rx_state_d = R_IDLE;
          end else begin
            frame_err_d = 1'b1;         // byte discarded; resync on the next idle level
            rx_state_d  = R_WAITHI;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      R_WAITHI: begin
        if (rx_s) rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // RX state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------- translation
  // Returns {mapped, index}; unmapped bytes come back with mapped=0 and are dropped.
  function automatic logic [6:0] kbd_map(input logic [7:0] b);
    logic [6:0] r;
    r = 7'd0;
    if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) begin
      r = {1'b1, 1'b0, b[4:0]};
    end else if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, 6'd32 + {2'b00, b[3:0]}};
    end else begin
      case (b)
        8'h20:        r = {1'b1, 6'd31};
        8'h3B:        r = {1'b1, 6'd42};
        8'h3A:        r = {1'b1, 6'd43};
        8'h2C:        r = {1'b1, 6'd44};
        8'h3D:        r = {1'b1, 6'd45};
        8'h2E:        r = {1'b1, 6'd46};
        8'h2F:        r = {1'b1, 6'd47};
        8'h0D:        r = {1'b1, 6'd48};
        8'h1B:        r = {1'b1, 6'd49};
        8'h08, 8'h7F: r = {1'b1, 6'd51};
        default:      r = 7'd0;
      endcase
    end
    return r;
  endfunction

  logic [6:0] map_res;
  logic       fifo_wr_vld, fifo_wr_rdy;
  logic       fifo_rd_vld, fifo_rd_rdy;
  logic [5:0] fifo_rd_dat;

  // Translate the freshly received byte; only mapped bytes reach the FIFO.
  always_comb begin
    map_res     = kbd_map(shift_q);
    fifo_wr_vld = byte_vld_q & map_res[6];
  end

  galaksija_kbd_fifo #(
    .WIDTH (6),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (fifo_wr_vld),
    .wr_dat  (map_res[5:0]),
    .wr_rdy  (fifo_wr_rdy),
    .rd_vld  (fifo_rd_vld),
    .rd_rdy  (fifo_rd_rdy),
    .rd_dat  (fifo_rd_dat)
  );

  // ---------------------------------------------------------------- press FSM
  press_state_t     p_state_q, p_state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [5:0]       press_idx_q, press_idx_d;
  logic             active_q, active_d;
  logic             overflow_q, overflow_d;

  // Replay: pop one index, hold it for HOLD_CYC, then release for GAP_CYC before the next.
  always_comb begin
    p_state_d   = p_state_q;
    tmr_d       = tmr_q;
    press_idx_d = press_idx_q;
    active_d    = active_q;
    fifo_rd_rdy = 1'b0;
    case (p_state_q)
      P_IDLE: begin
        fifo_rd_rdy = 1'b1;
        if (fifo_rd_vld) begin
          press_idx_d = fifo_rd_dat;
          active_d    = 1'b1;
          tmr_d       = HOLD_LOAD;
          p_state_d   = P_PRESS;
        end
      end
      P_PRESS: begin
        if (tmr_q == '0) begin
          active_d  = 1'b0;
          tmr_d     = GAP_LOAD;
          p_state_d = P_GAP;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      P_GAP: begin
        if (tmr_q == '0) p_state_d = P_IDLE;
        else             tmr_d     = tmr_q - 1'b1;
      end
      default: p_state_d = P_IDLE;
    endcase
    overflow_d = overflow_q | (fifo_wr_vld & ~fifo_wr_rdy);
  end

  // Press state registers; reset drops any press in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_state_q   <= P_IDLE;
      tmr_q       <= '0;
      press_idx_q <= 6'd0;
      active_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      p_state_q   <= p_state_d;
      tmr_q       <= tmr_d;
      press_idx_q <= press_idx_d;
      active_q    <= active_d;
      overflow_q  <= overflow_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  // Matrix merge stays combinational in addr so the CPU sees it within its read cycle.
  assign mtx.key_out = mtx.key_in & ~(active_q & (mtx.addr == press_idx_q));
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign busy        = (p_state_q != P_IDLE) | fifo_rd_vld;
endmodule
